// File: rtl/tcdm_responder_pkg.sv
// Shared types and constants for the TCDM responder slice.
// Build option: TCDM_RESPONDER_STALL_EN enables the LFSR-driven port stall mask.
package tcdm_responder_package;

    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = 4;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic               r_valid;
        logic [TCDM_DW-1:0] r_data;
    } tcdm_resp_t;

    // Width of a select field for n entries; never narrower than one bit so
    // bank_sel_t / row_sel_t stay legal for single-entry configurations.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// HWPE TCDM request/response bundle, one instance per port.
interface hwpe_stream_intf_tcdm;

    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/tcdm_responder_rr_arbiter.sv
// Per-bank round-robin arbiter: one-hot grant to the first requester at or
// after the pointer; the pointer moves past the winner on every grant.
module tcdm_rr_arbiter
    import tcdm_responder_package::*;
#(
    parameter int unsigned MP = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic [MP-1:0] req,
    output logic [MP-1:0] gnt
);

    localparam int unsigned PTR_W = sel_width(MP);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] winner;
    logic             any;

    // Scan requesters starting at the pointer, wrapping, and keep the first hit
    always_comb begin
        gnt    = '0;
        idx    = '0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < MP; i++) begin
            idx = PTR_W'((32'(ptr) + i) % MP);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
        if (any) begin
            gnt[winner] = 1'b1;
        end
    end

    // Pointer advances to winner+1 on a grant, holds otherwise, zeroed by clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (clear_i) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= PTR_W'((32'(winner) + 1) % MP);
        end
    end

endmodule

// File: rtl/tcdm_responder.sv
// TCDM responder: MP slave ports served from a word-interleaved banked
// flop scratchpad, per-bank round-robin arbitration, 1-cycle responses.
// Build option: TCDM_RESPONDER_STALL_EN adds a 16-bit LFSR that stalls
// port p whenever lfsr[p mod 16] is set.
module tcdm_responder
    import tcdm_responder_package::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned N_BANKS    = 8,
    parameter int unsigned BANK_DEPTH = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 clear_i,
    hwpe_stream_intf_tcdm.slave tcdm [MP-1:0]
);

    localparam int unsigned BANK_W = sel_width(N_BANKS);
    localparam int unsigned ROW_W  = sel_width(BANK_DEPTH);

    typedef logic [BANK_W-1:0] bank_sel_t;
    typedef logic [ROW_W-1:0]  row_sel_t;

    logic [MP-1:0]       req;
    logic [MP-1:0]       wen;
    logic [MP-1:0]       gnt;
    logic [MP-1:0]       stall;
    logic [TCDM_DW-1:0]  wdata [MP];
    logic [TCDM_BEW-1:0] be [MP];
    bank_sel_t           bank [MP];
    row_sel_t            row [MP];

    logic [MP-1:0]       bank_gnt [N_BANKS];
    logic [TCDM_DW-1:0]  bank_rdata [N_BANKS];

    // Interface array is flattened per port so bank logic can index ports freely
    for (genvar p = 0; p < MP; p++) begin : g_port
        logic [31:0] word;
        tcdm_resp_t  resp;

        assign req[p]   = tcdm[p].req;
        assign wen[p]   = tcdm[p].wen;
        assign be[p]    = tcdm[p].be;
        assign wdata[p] = tcdm[p].data;
        assign word     = tcdm[p].add >> 2;
        assign bank[p]  = BANK_W'(word % N_BANKS);
        assign row[p]   = ROW_W'((word / N_BANKS) % BANK_DEPTH);

        // Response register: one pulse per grant, data held between pulses
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                resp <= '0;
            end else if (clear_i) begin
                resp.r_valid <= 1'b0;
            end else begin
                resp.r_valid <= gnt[p];
                if (gnt[p]) begin
                    resp.r_data <= wen[p] ? bank_rdata[bank[p]] : '0;
                end
            end
        end

        assign tcdm[p].gnt     = gnt[p];
        assign tcdm[p].r_valid = resp.r_valid;
        assign tcdm[p].r_data  = resp.r_data;
    end

`ifdef TCDM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR providing pseudo-random back-pressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    for (genvar p = 0; p < MP; p++) begin : g_stall
        assign stall[p] = lfsr[p % 16];
    end
`else
    logic unused_lfsr_seed;
    assign unused_lfsr_seed = ^LFSR_SEED;
    assign stall = '0;
`endif

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [MP-1:0]       bank_req;
        logic [TCDM_DW-1:0]  mem [BANK_DEPTH];
        row_sel_t            sel_row;
        logic                sel_any;
        logic                sel_rd;
        logic [TCDM_BEW-1:0] sel_be;
        logic [TCDM_DW-1:0]  sel_data;

        // Candidates: requesting, unstalled ports targeting this bank, none during clear
        always_comb begin
            bank_req = '0;
            for (int unsigned p = 0; p < MP; p++) begin
                bank_req[p] = req[p] & ~stall[p] & ~clear_i & (bank[p] == BANK_W'(b));
            end
        end

        tcdm_rr_arbiter #(
            .MP (MP)
        ) i_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .req     (bank_req),
            .gnt     (bank_gnt[b])
        );

        // One-hot grant lets an OR-mux pick the winner's row and write payload
        always_comb begin
            sel_row  = '0;
            sel_any  = 1'b0;
            sel_rd   = 1'b0;
            sel_be   = '0;
            sel_data = '0;
            for (int unsigned p = 0; p < MP; p++) begin
                if (bank_gnt[b][p]) begin
                    sel_row  = sel_row | row[p];
                    sel_any  = 1'b1;
                    sel_rd   = sel_rd | wen[p];
                    sel_be   = sel_be | be[p];
                    sel_data = sel_data | wdata[p];
                end
            end
        end

        // Bank storage with byte-lane write enables
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned r = 0; r < BANK_DEPTH; r++) begin
                    mem[r] <= '0;
                end
            end else if (sel_any && !sel_rd) begin
                for (int unsigned k = 0; k < TCDM_BEW; k++) begin
                    if (sel_be[k]) begin
                        mem[sel_row][8*k +: 8] <= sel_data[8*k +: 8];
                    end
                end
            end
        end

        assign bank_rdata[b] = mem[sel_row];
    end

    // A port is granted when it wins whichever bank it addressed
    always_comb begin
        gnt = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            gnt = gnt | bank_gnt[b];
        end
    end

endmodule

// File: tb/tb_tcdm_responder.sv
// Scoreboard bench for tcdm_responder: a word-level memory model predicts
// grants and responses; a monitor pops expected responses as they appear.
module tb_tcdm_responder;

    localparam int          MP         = 4;
    localparam int          N_BANKS    = 8;
    localparam int          BANK_DEPTH = 256;
    localparam int          WORDS      = N_BANKS * BANK_DEPTH;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic        clk    = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear  = 1'b0;
    logic [MP-1:0] req;
    logic [MP-1:0] wen;
    logic [31:0]   add [MP];
    logic [31:0]   data [MP];
    logic [3:0]    be [MP];
    logic [MP-1:0] gnt;
    logic [MP-1:0] r_valid;
    logic [31:0]   r_data [MP];

    hwpe_stream_intf_tcdm tcdm_if [MP-1:0] ();

    for (genvar p = 0; p < MP; p++) begin : g_bridge
        assign tcdm_if[p].req  = req[p];
        assign tcdm_if[p].wen  = wen[p];
        assign tcdm_if[p].add  = add[p];
        assign tcdm_if[p].data = data[p];
        assign tcdm_if[p].be   = be[p];
        assign gnt[p]          = tcdm_if[p].gnt;
        assign r_valid[p]      = tcdm_if[p].r_valid;
        assign r_data[p]       = tcdm_if[p].r_data;
    end

    tcdm_responder #(
        .MP         (MP),
        .N_BANKS    (N_BANKS),
        .BANK_DEPTH (BANK_DEPTH),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .clear_i (clear),
        .tcdm    (tcdm_if)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] ref_mem [WORDS];
    int          rr [N_BANKS];
    logic [15:0] lfsr_m;
    logic [31:0] exp_q [MP][$];
    logic [31:0] last_rdata [MP];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 2) % N_BANKS);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WORDS; w++) ref_mem[w] = '0;
        for (int b = 0; b < N_BANKS; b++) rr[b] = 0;
        for (int p = 0; p < MP; p++) begin
            exp_q[p].delete();
            last_rdata[p] = '0;
        end
        lfsr_m = SEED;
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step(output logic [MP-1:0] g, output logic [MP-1:0] dg);
        logic [MP-1:0] stl;
        logic [MP-1:0] exp_g;
        int            nrr [N_BANKS];
        int            pi;
        int            w;
        #3;
        stl = '0;
`ifdef TCDM_RESPONDER_STALL_EN
        for (int p = 0; p < MP; p++) stl[p] = lfsr_m[p % 16];
`endif
        exp_g = '0;
        for (int b = 0; b < N_BANKS; b++) nrr[b] = clear ? 0 : rr[b];
        if (!clear) begin
            for (int b = 0; b < N_BANKS; b++) begin
                for (int k = 0; k < MP; k++) begin
                    pi = (rr[b] + k) % MP;
                    if (req[pi] && !stl[pi] && bank_of(add[pi]) == b) begin
                        exp_g[pi] = 1'b1;
                        nrr[b]    = (pi + 1) % MP;
                        break;
                    end
                end
            end
        end
        dg = gnt;
        check("gnt", 32'(gnt), 32'(exp_g));
        for (int p = 0; p < MP; p++) begin
            if (exp_g[p]) exp_q[p].push_back(wen[p] ? ref_mem[word_of(add[p])] : 32'h0);
        end
        for (int p = 0; p < MP; p++) begin
            if (exp_g[p] && !wen[p]) begin
                w = word_of(add[p]);
                for (int k = 0; k < 4; k++)
                    if (be[p][k]) ref_mem[w][8*k +: 8] = data[p][8*k +: 8];
            end
        end
        for (int b = 0; b < N_BANKS; b++) rr[b] = nrr[b];
        if (rst_ni) lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        g = exp_g;
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic rd, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        wen[p]  = rd;
        add[p]  = a;
        be[p]   = b;
        data[p] = d;
    endtask

    // Holds requests until each is granted, bounded.
    task automatic run_pending(input string name);
        logic [MP-1:0] g;
        logic [MP-1:0] dg;
        int            n;
        n = 0;
        while (req != '0 && n < 64) begin
            step(g, dg);
            req = req & ~g;
            n++;
        end
        if (req != '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: pending req %b, required all granted", name, req);
            req = '0;
        end
    endtask

    task automatic xfer(input int p, input logic rd, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        set_req(p, rd, a, b, d);
        run_pending($sformatf("xfer p%0d @%h", p, a));
    endtask

    // Monitor: each cycle, a pending expectation must meet r_valid, and vice versa
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < MP; p++) begin
            if (r_valid[p] === 1'b1) begin
                if (exp_q[p].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected p%0d: r_valid=1 r_data=%h, required no response", p, r_data[p]);
                end else begin
                    check($sformatf("rsp_data p%0d", p), r_data[p], exp_q[p].pop_front());
                end
                last_rdata[p] = r_data[p];
            end else if (exp_q[p].size() != 0) begin
                void'(exp_q[p].pop_front());
                n_tests++;
                n_fail++;
                $display("FAIL rsp_missing p%0d: r_valid=%b, required 1", p, r_valid[p]);
            end else begin
                check($sformatf("rdata_hold p%0d", p), r_data[p], last_rdata[p]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MP-1:0] g;
        logic [MP-1:0] dg;
        int            cnt [MP];
        int            wd;

        req = '0;
        wen = '0;
        for (int p = 0; p < MP; p++) begin
            add[p]  = '0;
            data[p] = '0;
            be[p]   = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Reset state
        check("reset_rvalid", 32'(r_valid), 32'h0);
        check("reset_rdata0", r_data[0], 32'h0);
        step(g, dg);

        // Write then read back, write response carries zero
        xfer(0, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF);
        check("wr_rsp_zero_a", last_rdata[0], 32'h0);
        xfer(0, 1'b1, 32'h100, 4'hF, 32'h0);
        check("rd_deadbeef", last_rdata[0], 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h104, 4'hF, 32'h01020304);
        check("wr_rsp_zero_b", last_rdata[0], 32'h0);

        // Byte enables
        xfer(1, 1'b0, 32'h40, 4'hF, 32'h11223344);
        xfer(1, 1'b0, 32'h40, 4'b0101, 32'hAABBCCDD);
        xfer(1, 1'b1, 32'h40, 4'h0, 32'h0);
        check("byte_enable", last_rdata[1], 32'h11BB33DD);
        xfer(1, 1'b0, 32'h40, 4'h0, 32'hFFFFFFFF);
        xfer(1, 1'b1, 32'h40, 4'h0, 32'h0);
        check("be_zero_nochange", last_rdata[1], 32'h11BB33DD);

        // Address wrap-around
        xfer(2, 1'b0, 32'h2000, 4'hF, 32'h5A5A5A5A);
        xfer(2, 1'b1, 32'h0, 4'h0, 32'h0);
        check("wrap_rd0", last_rdata[2], 32'h5A5A5A5A);
        xfer(3, 1'b1, 32'h8000_0002, 4'h0, 32'h0);
        check("wrap_highbits", last_rdata[3], 32'h5A5A5A5A);

        // No conflict: four ports on four banks
        for (int p = 1; p < MP; p++) set_req(p, 1'b0, 32'(p * 4), 4'hF, 32'hA0 + 32'(p));
        run_pending("nc_write");
        for (int p = 0; p < MP; p++) set_req(p, 1'b1, 32'(p * 4), 4'h0, 32'h0);
`ifndef TCDM_RESPONDER_STALL_EN
        step(g, dg);
        check("no_conflict_gnt", 32'(dg), 32'hF);
        req = req & ~g;
`endif
        run_pending("nc_read");
        check("nc_rd0", last_rdata[0], 32'h5A5A5A5A);
        check("nc_rd1", last_rdata[1], 32'hA1);
        check("nc_rd3", last_rdata[3], 32'hA3);

        // Clear zeroes pointers and blocks grants for that cycle
        set_req(0, 1'b1, 32'h0, 4'h0, 32'h0);
        clear = 1'b1;
        step(g, dg);
        clear = 1'b0;
        check("clear_no_gnt", 32'(dg), 32'h0);
        req = '0;

        // Conflict: all ports hammer bank 0
        for (int p = 0; p < MP; p++) begin
            set_req(p, 1'b1, 32'(p * 32), 4'h0, 32'h0);
            cnt[p] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            step(g, dg);
            for (int p = 0; p < MP; p++) if (dg[p]) cnt[p]++;
`ifndef TCDM_RESPONDER_STALL_EN
            check($sformatf("rr_order c%0d", c), 32'(dg), 32'(1 << (c % 4)));
`endif
        end
`ifndef TCDM_RESPONDER_STALL_EN
        for (int p = 0; p < MP; p++) check($sformatf("rr_count p%0d", p), 32'(cnt[p]), 32'd2);
`endif
        req = '0;
        step(g, dg);

        // Reset right after a grant drops the response
        set_req(0, 1'b0, 32'h100, 4'hF, 32'h12345678);
        #3;
`ifndef TCDM_RESPONDER_STALL_EN
        check("pre_rst_gnt", 32'(gnt), 32'h1);
`endif
        rst_ni = 1'b0;
        req    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(g, dg);
            check($sformatf("post_rst_rvalid c%0d", c), 32'(r_valid), 32'h0);
        end
        xfer(0, 1'b1, 32'h100, 4'h0, 32'h0);
        check("mem_after_reset", last_rdata[0], 32'h0);

        // Random traffic against the reference model
        for (int c = 0; c < 1000; c++) begin
            for (int p = 0; p < MP; p++) begin
                if (!req[p] && $urandom_range(0, 9) < 6) begin
                    wd = $urandom_range(0, 47) + $urandom_range(0, 3) * WORDS;
                    set_req(p, 1'($urandom_range(0, 1)),
                            ($urandom() & 32'hF000_0000) | (32'(wd) << 2) | 32'($urandom_range(0, 3)),
                            4'($urandom_range(0, 15)), $urandom());
                end
            end
            clear = ($urandom_range(0, 99) == 0);
            step(g, dg);
            clear = 1'b0;
            req = req & ~g;
        end
        req = '0;
        repeat (2) step(g, dg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
